mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single read-only memory wrapper port (mem_wrapper: address/read/readdata/readdatavalid/waitrequest) between NUM_REQ read requesters, e.g. the FIFO fill engine and a result/weight loader.
- Round-robin arbitration, one outstanding read at a time.
- Each requester sees an unmodified memory-style slave port. Requesters are unaware of sharing apart from added waitrequest cycles.

Parameters:
- NUM_REQ, 2, number of requester ports (≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, read data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_address  in  NUM_REQ*ADDR_WIDTH  requester addresses; slice i = requester i.
- req_read  in  NUM_REQ  read request per requester.
- req_waitrequest  out  NUM_REQ  stall per requester; read is accepted in a cycle where read=1 and waitrequest=0.
- req_readdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- req_readdatavalid  out  NUM_REQ  data-valid strobe, asserted only to the owning requester.
- mem_address  out  ADDR_WIDTH  to memory wrapper.
- mem_read  out  1  to memory wrapper.
- mem_readdata  in  DATA_WIDTH  from memory wrapper.
- mem_readdatavalid  in  1  from memory wrapper.
- mem_waitrequest  in  1  from memory wrapper.
- grant  out  NUM_REQ  one-hot current owner; 0 when IDLE.
- stray_valid  out  1  sticky error flag: mem_readdatavalid received outside WAIT_DATA.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=NUM_REQ-1 (so requester 0 wins first), stray_valid=0.
  - mem_read=0, req_waitrequest=all 1, req_readdatavalid=0.
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE:
  - All req_waitrequest=1 and mem_read=0.
  - If any req_read is high, grant is registered to the first requesting index searching from last_grant+1 upward, wrapping modulo NUM_REQ. Next state is ISSUE.
  - Arbitration costs exactly 1 cycle.
- ISSUE:
  - mem_address = req_address slice of the granted requester (combinational mux).
  - mem_read = req_read[grant].
  - req_waitrequest[grant] = mem_waitrequest; all others remain 1.
  - mem_read=1 and mem_waitrequest=0 → accepted; go to WAIT_DATA.
  - Granted requester drops read before acceptance (protocol violation) → return to IDLE, no memory transaction issued, last_grant unchanged.
- WAIT_DATA:
  - mem_read=0 and all req_waitrequest=1.
  - req_readdata = mem_readdata at all times (pass-through).
  - req_readdatavalid[grant] = mem_readdatavalid, combinational, same cycle.
  - On mem_readdatavalid: last_grant←grant, grant←0, next state IDLE.
- Latency: requester read accepted 1 + (mem waitrequest cycles) after first assertion. Data returns in the same cycle the memory returns it; no added data latency.
- Back-to-back: a request present in the readdatavalid cycle is arbitrated in the following IDLE cycle. Minimum spacing between transactions is 1 IDLE cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other transactions.
- mem_readdatavalid in IDLE or ISSUE: ignored (not routed) and sets stray_valid. Only reset clears stray_valid.
- Reset mid-transaction: asynchronous return to reset values. The memory wrapper shares rst_n, so no response survives reset.
- Single requester active: it is re-granted every transaction, still with the 1-cycle IDLE gap.
- grant is one-hot or zero at all times; this is asserted in the bench.

Decomposition:
- Package mem_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT_DATA}.
  - Helper function onehot_to_idx.
- Sub-module rr_picker, combinational:
  - Inputs: req vector, last_grant index.
  - Output: one-hot winner plus valid.
  - Implemented as a double-width masked priority search.
- Top level holds the FSM, the registered grant/last_grant, the address mux and the response routing.

Test Plan:
- Req0 only, address 0x10, mem_waitrequest=0, data 0x1122334455667788 after 2 cycles → req_waitrequest[0] low 1 cycle after req_read rises; req_readdatavalid[0]=1 with that data; req_readdatavalid[1] never asserts.
- Req0 and req1 asserted together right after reset, addresses 0x0 and 0x8 → mem_address sequence 0x0 then 0x8; grant 01 then 10.
- Both requesters hold read continuously for 6 transactions → grant alternates 0,1,0,1,0,1; no requester serviced twice in a row.
- mem_waitrequest held high 3 cycles in ISSUE → mem_address and mem_read stable for all 3 cycles; req_waitrequest[grant] tracks the stall; acceptance on the 4th cycle.
- mem_readdatavalid pulsed while IDLE → no req_readdatavalid; stray_valid=1 and stays 1 until rst_n low.
- rst_n asserted low during WAIT_DATA → immediately state=IDLE, grant=0, all req_waitrequest=1; after release, requester 0 wins first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory read arbiter.
//   arb_state_t    : arbiter FSM states
//   onehot_to_idx  : converts a one-hot (or zero) vector to a binary index
package mem_arb_pkg;

  // Upper bound on requester count accepted by onehot_to_idx.
  localparam int unsigned MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA
  } arb_state_t;

  // OR-reduction of set bit positions; exact for one-hot input, 0 for all-zero input.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Bus bundle between NUM_REQ read requesters, the arbiter and the memory wrapper.
//   req_*  : per-requester memory-style read ports (address slice i = requester i)
//   mem_*  : single shared port toward the memory wrapper
// Modports:
//   slave  : the arbiter's view (requesters drive it, it drives the memory)
//   master : the environment's view (requesters plus memory wrapper)
interface mem_read_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);

  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ-1:0]            req_read;
  logic [NUM_REQ-1:0]            req_waitrequest;
  logic [DATA_WIDTH-1:0]         req_readdata;
  logic [NUM_REQ-1:0]            req_readdatavalid;

  logic [ADDR_WIDTH-1:0]         mem_address;
  logic                          mem_read;
  logic [DATA_WIDTH-1:0]         mem_readdata;
  logic                          mem_readdatavalid;
  logic                          mem_waitrequest;

  modport slave (
    input  req_address, req_read, mem_readdata, mem_readdatavalid, mem_waitrequest,
    output req_waitrequest, req_readdata, req_readdatavalid, mem_address, mem_read
  );

  modport master (
    output req_address, req_read, mem_readdata, mem_readdatavalid, mem_waitrequest,
    input  req_waitrequest, req_readdata, req_readdatavalid, mem_address, mem_read
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index of the previous winner; search starts at last_grant+1
//   winner     : one-hot winner (zero when no request)
//   valid      : at least one request present
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]   winner,
  output logic                 valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] mask;

  // Duplicating the request vector turns the wrap-around search into a plain
  // priority search over the window (last_grant, last_grant+NUM_REQ].
  always_comb begin
    req_dbl = {req, req};
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      mask[i] = (i > int'(last_grant)) && (i <= int'(last_grant) + int'(NUM_REQ));
    end
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!valid && mask[i] && req_dbl[i]) begin
        valid = 1'b1;
        winner[i % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one read-only memory wrapper port between NUM_REQ
// requesters, one outstanding read at a time.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : requester and memory ports (mem_read_arbiter_if.slave)
//   grant       : one-hot current owner, zero while idle
//   stray_valid : sticky flag, memory returned data while no read was outstanding
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_read_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               stray_valid
);

  localparam int unsigned IDX_WIDTH = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                   stray_q, stray_d;

  logic [NUM_REQ-1:0]     pick_winner;
  logic                   pick_valid;
  logic [IDX_WIDTH-1:0]   grant_idx;

  logic [NUM_REQ-1:0]     waitreq;
  logic [NUM_REQ-1:0]     rdvalid;
  logic                   mem_rd;
  logic [ADDR_WIDTH-1:0]  mem_addr;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (bus.req_read),
    .last_grant (last_grant_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign grant_idx = IDX_WIDTH'(onehot_to_idx(MAX_REQ'(grant_q)));
  assign mem_addr  = bus.req_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stray_d      = stray_q;
    waitreq      = '1;
    rdvalid      = '0;
    mem_rd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_readdatavalid) stray_d = 1'b1;
        if (pick_valid) begin
          grant_d = pick_winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_readdatavalid) stray_d = 1'b1;
        mem_rd             = bus.req_read[grant_idx];
        waitreq[grant_idx] = bus.mem_waitrequest;
        if (!bus.req_read[grant_idx]) begin
          // Requester withdrew before acceptance: abandon without touching fairness.
          grant_d = '0;
          state_d = IDLE;
        end else if (!bus.mem_waitrequest) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        rdvalid[grant_idx] = bus.mem_readdatavalid;
        if (bus.mem_readdatavalid) begin
          last_grant_d = grant_idx;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_WIDTH'(NUM_REQ - 1);
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stray_q      <= stray_d;
    end
  end

  assign bus.mem_address       = mem_addr;
  assign bus.mem_read          = mem_rd;
  assign bus.req_waitrequest   = waitreq;
  assign bus.req_readdatavalid = rdvalid;
  assign bus.req_readdata      = bus.mem_readdata;
  assign grant                 = grant_q;
  assign stray_valid           = stray_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: stimulus pushes expected accepts and
// responses; a monitor pops and compares whenever the DUT presents them.
module tb_mem_read_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] grant;
  logic          stray_valid;

  int total = 0;
  int bad   = 0;
  int rsp_lat = 2;
  int rst_gen = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          acc_r_q[$];
  logic [31:0] acc_a_q[$];
  int          dat_r_q[$];
  logic [63:0] dat_d_q[$];

  logic        acc0, acc1;
  int          mon_r;
  logic [31:0] mon_a;
  logic [63:0] mon_d;
  logic [31:0] rsp_addr;
  int          rsp_gen, rsp_l;

  mem_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_read_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant       (grant),
    .stray_valid (stray_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    if (a == 32'h10) return 64'h1122334455667788;
    return {32'hCAFE0000, a};
  endfunction

  task automatic push_txn(input int r, input logic [31:0] a, input logic [63:0] d);
    acc_r_q.push_back(r);
    acc_a_q.push_back(a);
    dat_r_q.push_back(r);
    dat_d_q.push_back(d);
    if (r == 0) q0.push_back(a);
    else q1.push_back(a);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((acc_r_q.size() != 0 || dat_r_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed"}, 64'(acc_r_q.size() == 0 && dat_r_q.size() == 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: holds read with the head address until accepted.
  initial begin
    bus.req_read    = '0;
    bus.req_address = '0;
    forever begin
      @(negedge clk);
      acc0 = bus.req_read[0] && !bus.req_waitrequest[0];
      acc1 = bus.req_read[1] && !bus.req_waitrequest[1];
      @(posedge clk);
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      if (q0.size() != 0) begin
        bus.req_read[0] = 1'b1;
        bus.req_address[31:0] = q0[0];
      end else begin
        bus.req_read[0] = 1'b0;
      end
      if (q1.size() != 0) begin
        bus.req_read[1] = 1'b1;
        bus.req_address[63:32] = q1[0];
      end else begin
        bus.req_read[1] = 1'b0;
      end
    end
  end

  // Memory wrapper model: answers rsp_lat cycles after acceptance unless reset intervenes.
  initial begin
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata      = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_read && !bus.mem_waitrequest) begin
        rsp_addr = bus.mem_address;
        rsp_gen  = rst_gen;
        rsp_l    = rsp_lat;
        @(posedge clk);
        for (int k = 1; k < rsp_l; k++) begin
          @(posedge clk);
          if (rsp_gen != rst_gen) break;
        end
        #1;
        if (rsp_gen == rst_gen) begin
          bus.mem_readdata      = mem_data(rsp_addr);
          bus.mem_readdatavalid = 1'b1;
          @(posedge clk);
          #1 bus.mem_readdatavalid = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (bus.mem_read && !bus.mem_waitrequest) begin
        if (acc_r_q.size() == 0) begin
          check("unexpected_accept", 64'(bus.mem_read), 64'd0);
        end else begin
          mon_r = acc_r_q.pop_front();
          mon_a = acc_a_q.pop_front();
          check("accept_addr", 64'(bus.mem_address), 64'(mon_a));
          check("accept_grant", 64'(grant), 64'(1 << mon_r));
        end
      end
      if (bus.req_readdatavalid != '0) begin
        if (dat_r_q.size() == 0) begin
          check("unexpected_rdvalid", 64'(bus.req_readdatavalid), 64'd0);
        end else begin
          mon_r = dat_r_q.pop_front();
          mon_d = dat_d_q.pop_front();
          check("rdvalid_owner", 64'(bus.req_readdatavalid), 64'(1 << mon_r));
          check("rdata", bus.req_readdata, mon_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.mem_waitrequest = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_waitreq", 64'(bus.req_waitrequest), 64'h3);
    check("rst_rdvalid", 64'(bus.req_readdatavalid), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check("rst_stray", 64'(stray_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests after reset: requester 0 first.
    push_txn(0, 32'h0, 64'hCAFE0000_00000000);
    push_txn(1, 32'h8, 64'hCAFE0000_00000008);
    drain("both_after_reset");

    // Continuous requests: strict alternation.
    push_txn(0, 32'h100, 64'hCAFE0000_00000100);
    push_txn(1, 32'h200, 64'hCAFE0000_00000200);
    push_txn(0, 32'h110, 64'hCAFE0000_00000110);
    push_txn(1, 32'h210, 64'hCAFE0000_00000210);
    push_txn(0, 32'h120, 64'hCAFE0000_00000120);
    push_txn(1, 32'h220, 64'hCAFE0000_00000220);
    drain("alternate6");

    // Single requester, 1-cycle arbitration latency.
    rsp_lat = 2;
    push_txn(0, 32'h10, 64'h1122334455667788);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("idle_waitreq0", 64'(bus.req_waitrequest[0]), 64'd1);
    @(negedge clk);
    check("issue_waitreq0", 64'(bus.req_waitrequest[0]), 64'd0);
    check("issue_grant", 64'(grant), 64'h1);
    drain("req0_only");

    // Memory stall for 3 ISSUE cycles.
    rsp_lat = 1;
    bus.mem_waitrequest = 1'b1;
    push_txn(0, 32'h40, 64'hCAFE0000_00000040);
    @(posedge clk);
    #2;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_mem_read", 64'(bus.mem_read), 64'd1);
      check("stall_mem_addr", 64'(bus.mem_address), 64'h40);
      check("stall_waitreq", 64'(bus.req_waitrequest), 64'h3);
      check("stall_grant", 64'(grant), 64'h1);
    end
    @(posedge clk);
    #1 bus.mem_waitrequest = 1'b0;
    @(negedge clk);
    check("stall_release_waitreq", 64'(bus.req_waitrequest), 64'h2);
    drain("stall");

    // Stray response while idle.
    @(posedge clk);
    #1 bus.mem_readdatavalid = 1'b1;
    @(negedge clk);
    check("stray_not_routed", 64'(bus.req_readdatavalid), 64'd0);
    @(posedge clk);
    #1 bus.mem_readdatavalid = 1'b0;
    @(negedge clk);
    check("stray_set", 64'(stray_valid), 64'd1);
    push_txn(0, 32'h400, 64'hCAFE0000_00000400);
    drain("after_stray");
    check("stray_sticky", 64'(stray_valid), 64'd1);

    // Reset during WAIT_DATA.
    rsp_lat = 6;
    push_txn(0, 32'h80, 64'hCAFE0000_00000080);
    n = 0;
    while (acc_r_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_accepted", 64'(acc_r_q.size()), 64'd0);
    @(negedge clk);
    check("midrst_wait_grant", 64'(grant), 64'h1);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    dat_r_q.delete();
    dat_d_q.delete();
    #1;
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_waitreq", 64'(bus.req_waitrequest), 64'h3);
    check("midrst_mem_read", 64'(bus.mem_read), 64'd0);
    check("midrst_stray", 64'(stray_valid), 64'd0);
    rsp_lat = 2;
    push_txn(0, 32'h88, 64'hCAFE0000_00000088);
    push_txn(1, 32'h300, 64'hCAFE0000_00000300);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
